// File: rtl/fnd_pkg.sv
// Shared constants, FSM state type and segment font lookup for the FND scan controller.
package fnd_pkg;

    localparam int NUM_DIGITS  = 4;
    localparam int MAX_DISPLAY = 9999;
    localparam int BIN_W       = 14;
    localparam int BCD_W       = 4 * NUM_DIGITS;

    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    function automatic logic [7:0] nibble_font(input logic [3:0] nib);
        logic [7:0] f;
        case (nib)
            4'd0:    f = FONT_0;
            4'd1:    f = FONT_1;
            4'd2:    f = FONT_2;
            4'd3:    f = FONT_3;
            4'd4:    f = FONT_4;
            4'd5:    f = FONT_5;
            4'd6:    f = FONT_6;
            4'd7:    f = FONT_7;
            4'd8:    f = FONT_8;
            4'd9:    f = FONT_9;
            default: f = FONT_BLANK;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Load handshake between the arithmetic block and the FND scan controller.
interface fnd_scan_ctrl_if;
    import fnd_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic [BIN_W-1:0] i_value;

    modport master (
        output i_valid,
        output i_value,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_value,
        output o_ready
    );

endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: one add-3/shift step per cycle, BIN_W cycles per conversion.
module bin2bcd_serial
    import fnd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int SR_W  = BCD_W + BIN_W;

    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_adj;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (sr[BIN_W+4*d +: 4] >= 4'd5)
                sr_adj[BIN_W+4*d +: 4] = sr[BIN_W+4*d +: 4] + 4'd3;
        end
    end

    // done marks the edge that performs the final shift
    assign done = busy && (cnt == CNT_W'(BIN_W - 1));
    assign bcd  = sr[BIN_W +: BCD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sr   <= {{BCD_W{1'b0}}, bin};
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            sr  <= {sr_adj[SR_W-2:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND load/convert/scan controller.
// Optional FND_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    fnd_scan_ctrl_if.slave  load,
    input  logic            i_en,
    output logic [3:0]      o_digit,
    output logic [7:0]      o_fndFont,
    output logic            o_ovf
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_t state;
    state_t state_nxt;

    logic             xfer;
    logic             conv_start;
    logic             conv_done;
    logic [BIN_W-1:0] clamped;
    logic [BCD_W-1:0] conv_bcd;
    logic [BCD_W-1:0] disp;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       idx;
    logic             blank;
    logic [7:0]       cur_font;

    assign xfer    = conv_start;
    assign clamped = (load.i_value > BIN_W'(MAX_DISPLAY))
                   ? BIN_W'(MAX_DISPLAY) : load.i_value;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = CONV;
            CONV:    if (conv_done) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load.o_ready = 1'b0;
        conv_start   = 1'b0;
        case (state)
            IDLE: begin
                load.o_ready = 1'b1;
                conv_start   = load.i_valid;
            end
            default: ;
        endcase
    end

    bin2bcd_serial u_bin2bcd (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .start (conv_start),
        .bin   (clamped),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_ovf <= 1'b0;
            disp  <= '0;
        end else begin
            if (xfer)
                o_ovf <= (load.i_value > BIN_W'(MAX_DISPLAY));
            if (state == COMMIT)
                disp <= conv_bcd;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                idx <= idx + 1'b1;
        end
    end

    always_comb begin
        blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
        // blank when this digit and all to its left are zero
        blank = (idx != 2'd0) && ((disp >> (4 * idx)) == '0);
`endif
        cur_font = blank ? FONT_BLANK : nibble_font(disp[4*idx +: 4]);
        if (o_ovf && idx == 2'd0)
            cur_font[7] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_digit   <= 4'hF;
            o_fndFont <= FONT_BLANK;
        end else if (!i_en) begin
            o_digit   <= 4'hF;
            o_fndFont <= FONT_BLANK;
        end else begin
            o_digit   <= ~(4'b0001 << idx);
            o_fndFont <= cur_font;
        end
    end

endmodule
